v810_mem_target: RTL
====================

Name: v810_mem_target

Overview:
- Synthesizable data-bus responder for v810_exec; replaces the bench-only RAM model on the DA/DD/BEn/MRQn/RW bus.
- Decodes an address window and serves reads and writes from an internal word array.
- Inserts programmable wait states and signals completion with an active-low READYn handshake.
- Sits between the core's data port and on-chip RAM in the SoC top.

Parameters:
AW, 10, word-address bits; array holds 2**AW 32-bit words
BASE, 32'h0000_0000, window base; must be aligned to 2**(AW+2) bytes
WS_DEFAULT, 0, wait states used when WS_OVR=0

Ports:
CLK  in  1  clock
RESn  in  1  asynchronous active-low reset
CE  in  1  clock enable; all state advances only on CLK rising edge with CE=1
DA  in  32  byte address from initiator
DD_I  in  32  write data from initiator
DD_O  out  32  read data to initiator
BEn  in  4  active-low byte enables; bit i covers DD[8i+7:8i]
MRQn  in  1  active-low request
RW  in  1  1=read, 0=write
WS_OVR  in  1  1=use WS input instead of WS_DEFAULT
WS  in  4  runtime wait-state count
READYn  out  1  active-low transfer complete
HIT  out  1  registered: current transfer targets this block

Behaviour:
- Reset (RESn=0, asynchronous): state=IDLE, READYn=1, DD_O=0, HIT=0, wait counter=0. Array contents are not cleared.
- Hit condition: MRQn=0 and DA[31:AW+2]==BASE[31:AW+2]. DA[1:0] are ignored; word index = DA[AW+1:2].
- Effective wait count W = WS_OVR ? WS : WS_DEFAULT. W is sampled at request accept.
- FSM states: IDLE, WAIT, ACK.
- IDLE: on a CE edge with a hit, latch addr, RW, BEn and DD_I; set HIT=1; counter=W.
  - W==0: go to ACK.
  - W>0: go to WAIT.
  - Misses leave the block in IDLE with no outputs changed.
- WAIT: each CE edge decrements the counter. When the counter reaches 1, go to ACK. Total WAIT occupancy is exactly W cycles.
- ACK: READYn=0 for exactly one CE cycle.
  - Read: DD_O = array[latched addr], full word regardless of BEn.
  - Write: at the ACK-exit edge, array bytes with BEn[i]=0 take the latched DD_I bytes; other bytes are unchanged.
  - Next CE edge: go to IDLE, READYn=1, DD_O=0, HIT=0.
- Latency from request accept edge to READYn low: W+1 cycles. Minimum access is 2 cycles. A back-to-back request is accepted on the first IDLE edge after ACK.
- Initiator rules: hold DA, RW, BEn and DD_I stable from MRQn fall until READYn is sampled low. The latched copies make the target tolerant of violations.
- Abort: if MRQn=1 at any edge in WAIT or ACK, return to IDLE with READYn=1 and DD_O=0. No write is performed; a write in ACK that is aborted at that edge does not commit.
- Read-after-write to the same word in consecutive transfers returns the new data; no bypass is needed given the 2-cycle minimum.
- CE=0: FSM, counter and outputs hold; no array write.
- Reset during WAIT or ACK: transfer is dropped, no write commits, and the block is idle when RESn rises.
- Array read port: synchronous read is allowed if the array is read at the WAIT→ACK or IDLE→ACK transition, so DD_O is valid during ACK. This maps to block RAM.
- Debug task load_hex(fn) is provided for simulation only; it is excluded from synthesis.

Test Plan:
1. WS_DEFAULT=0: write 32'hDEADBEEF to DA=0x10 (BEn=0000), then read DA=0x10. READYn is low 1 cycle after each accept, and DD_O=32'hDEADBEEF in the read ACK cycle.
2. Byte enables: word 0x20=32'h11223344; write 32'hAABBCCDD with BEn=1010; read back 32'h11BB33DD.
3. WS_OVR=1, WS=3: read accepted at edge N gives READYn high at N+1..N+3 and low only in the cycle after edge N+3. Repeat with WS=15 and expect 16 cycles to READYn.
4. Abort: WS=4 write of 32'h12345678 to word 5 (previously 0), MRQn deasserted after 2 cycles. READYn never falls and a subsequent read returns 0.
5. Reset mid-op: assert RESn=0 asynchronously during WAIT of a write. READYn=1 and DD_O=0 immediately; the target word is unchanged; the next access completes normally.
6. Window/CE: access DA=BASE+2**(AW+2) gives no READYn and HIT=0. Hold CE=0 for 3 cycles during WAIT with WS=2; completion is delayed by exactly 3 cycles.

Source files
------------

// File: rtl/v810_mem_target_if.sv
// Data-bus signal bundle between the v810_exec data port and v810_mem_target.
// The initiator owns address/data/request; the target owns read data and handshake.
interface v810_mem_target_if;
  logic [31:0] DA;
  logic [31:0] DD_I;
  logic [31:0] DD_O;
  logic [3:0]  BEn;
  logic        MRQn;
  logic        RW;
  logic        WS_OVR;
  logic [3:0]  WS;
  logic        READYn;
  logic        HIT;

  modport master (
    output DA, DD_I, BEn, MRQn, RW, WS_OVR, WS,
    input  DD_O, READYn, HIT
  );

  modport slave (
    input  DA, DD_I, BEn, MRQn, RW, WS_OVR, WS,
    output DD_O, READYn, HIT
  );
endinterface

// File: rtl/v810_mem_target.sv
// Word-array responder for the v810_exec data bus: window decode, programmable wait
// states, active-low READYn completion, byte-enabled writes committed on ACK exit.
module v810_mem_target #(
  parameter int unsigned AW         = 10,
  parameter logic [31:0] BASE       = 32'h0000_0000,
  parameter int unsigned WS_DEFAULT = 0
) (
  input  logic              CLK,
  input  logic              RESn,
  input  logic              CE,
  v810_mem_target_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  logic [31:0]   mem [0:(2**AW)-1];

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic          rw_q;
  logic [3:0]    ben_q;
  logic [31:0]   wdata_q;

  logic          hit;
  logic [AW-1:0] idx;
  logic [3:0]    w_eff;
  logic          we;
  logic [1:0]    unused_byte_offset;

  assign hit   = !bus.MRQn && (bus.DA[31:AW+2] == BASE[31:AW+2]);
  assign idx   = bus.DA[AW+1:2];
  assign w_eff = bus.WS_OVR ? bus.WS : 4'(WS_DEFAULT);
  assign unused_byte_offset = bus.DA[1:0];

  // Commit only on a clean ACK exit; an abort (MRQn high) at that edge drops the write.
  assign we = CE && RESn && (state == S_ACK) && !bus.MRQn && !rw_q;

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bus.READYn <= 1'b1;
      bus.DD_O   <= '0;
      bus.HIT    <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b1;
      ben_q      <= '1;
      wdata_q    <= '0;
    end else if (CE) begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            addr_q  <= idx;
            rw_q    <= bus.RW;
            ben_q   <= bus.BEn;
            wdata_q <= bus.DD_I;
            bus.HIT <= 1'b1;
            cnt     <= w_eff;
            if (w_eff == 4'd0) begin
              // Zero-wait path reads with the live index since addr_q is not yet loaded.
              state      <= S_ACK;
              bus.READYn <= 1'b0;
              if (bus.RW) bus.DD_O <= mem[idx];
            end else begin
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (bus.MRQn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bus.READYn <= 1'b1;
            bus.DD_O   <= '0;
            bus.HIT    <= 1'b0;
          end else if (cnt == 4'd1) begin
            state      <= S_ACK;
            cnt        <= '0;
            bus.READYn <= 1'b0;
            if (rw_q) bus.DD_O <= mem[addr_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        S_ACK: begin
          state      <= S_IDLE;
          cnt        <= '0;
          bus.READYn <= 1'b1;
          bus.DD_O   <= '0;
          bus.HIT    <= 1'b0;
        end

        default: begin
          state      <= S_IDLE;
          cnt        <= '0;
          bus.READYn <= 1'b1;
          bus.DD_O   <= '0;
          bus.HIT    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!ben_q[i]) mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
